// File: rtl/hs32_fetch.sv
// HS32 instruction fetch stage: owns the PC, issues word fetches under a credit
// limit, buffers responses in a prefetch FIFO and handles redirects and bus errors.
package hs32_pkg;
    typedef logic [31:0] hs32_instr;
endpackage

module hs32_fetch
    import hs32_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        ib_req_o,
    output logic [31:0] ib_addr_o,
    input  logic        ib_gnt_i,
    input  logic        ib_rvalid_i,
    input  logic [31:0] ib_rdata_i,
    input  logic        ib_err_i,
    input  logic        br_valid_i,
    input  logic [31:0] br_addr_i,
    output hs32_instr   data_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        fault_o,
    input  logic        stall_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          halt_q, halt_d;

    hs32_instr     mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];
    logic          mem_err_q   [DEPTH];

    logic [CW:0]   credit;
    logic [31:0]   br_target;
    logic          fire, stale, push, pop;

    // Requests are masked by rstn so the bus sees no request while in reset.
    always_comb begin
        credit    = {1'b0, count_q} + {1'b0, outst_q};
        br_target = br_addr_i & ~32'h3;
        ib_req_o  = rstn && !halt_q && !br_valid_i && (credit < CREDIT_MAX);
        ib_addr_o = pc_q;
        fire      = ib_req_o && ib_gnt_i;
        stale     = ib_rvalid_i && (drop_q != '0);
        valid_o   = (count_q != '0);
        push      = ib_rvalid_i && !stale && !br_valid_i;
        pop       = valid_o && !stall_i && !br_valid_i;
        data_o    = valid_o ? mem_instr_q[rptr_q] : '0;
        pc_o      = valid_o ? mem_pc_q[rptr_q]    : '0;
        fault_o   = valid_o && mem_err_q[rptr_q];
    end

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        count_d  = count_q;
        outst_d  = outst_q + CW'(fire) - CW'(ib_rvalid_i);
        drop_d   = drop_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        halt_d   = halt_q;
        if (br_valid_i) begin
            // Everything still in flight becomes stale, except a response landing now.
            pc_d     = br_target;
            rsp_pc_d = br_target;
            halt_d   = 1'b0;
            drop_d   = outst_q - CW'(ib_rvalid_i);
            count_d  = '0;
            wptr_d   = '0;
            rptr_d   = '0;
        end else begin
            if (fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (stale) begin
                drop_d = drop_q - 1'b1;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wptr_d   = wptr_q + 1'b1;
                if (ib_err_i) begin
                    halt_d = 1'b1;
                end
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q     <= RESET_VEC;
            rsp_pc_q <= RESET_VEC;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            halt_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            halt_q   <= halt_d;
        end
    end

    // Storage holds no control state, so it is left unreset; outputs are gated by valid_o.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wptr_q] <= ib_rdata_i;
            mem_pc_q[wptr_q]    <= rsp_pc_q;
            mem_err_q[wptr_q]   <= ib_err_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && count_q == FULL));

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rstn)
        !(ib_rvalid_i && outst_q == '0));

endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: a randomised in-order bus responder plus an address-stream
// reference model (each redirect starts a new sequential stream of word fetches).
module tb_hs32_fetch;
    import hs32_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk;
    logic        rstn;
    logic        ib_req_o;
    logic [31:0] ib_addr_o;
    logic        ib_gnt_i;
    logic        ib_rvalid_i;
    logic [31:0] ib_rdata_i;
    logic        ib_err_i;
    logic        br_valid_i;
    logic [31:0] br_addr_i;
    hs32_instr   data_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        fault_o;
    logic        stall_i;

    logic        gnt_en;
    int          vecs = 0;
    int          errs = 0;

    hs32_fetch #(.RESET_VEC(RV), .DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .ib_req_o(ib_req_o), .ib_addr_o(ib_addr_o), .ib_gnt_i(ib_gnt_i),
        .ib_rvalid_i(ib_rvalid_i), .ib_rdata_i(ib_rdata_i), .ib_err_i(ib_err_i),
        .br_valid_i(br_valid_i), .br_addr_i(br_addr_i),
        .data_o(data_o), .pc_o(pc_o), .valid_o(valid_o), .fault_o(fault_o),
        .stall_i(stall_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ib_gnt_i = gnt_en && ib_req_o;

    // Bus memory contents and error map.
    logic [31:0] seed;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic errf(input logic [31:0] a);
        return err_en && (a == err_addr);
    endfunction

    // In-order responder: a request granted at edge N returns lat cycles later.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } txn_t;

    txn_t bq[$];
    int   lat     = 1;
    int   gnt_pct = 100;
    int   cyc     = 0;

    initial begin : bus_model
        logic        hs;
        logic [31:0] a;
        txn_t        t;
        ib_rvalid_i = 1'b0;
        ib_rdata_i  = '0;
        ib_err_i    = 1'b0;
        gnt_en      = 1'b1;
        forever begin
            @(negedge clk);
            hs = ib_req_o && ib_gnt_i && rstn;
            a  = ib_addr_o;
            @(posedge clk);
            #1;
            cyc++;
            if (!rstn) begin
                bq.delete();
                hs = 1'b0;
            end
            if (hs) begin
                t.addr = a;
                t.due  = cyc + lat - 1;
                bq.push_back(t);
            end
            if (rstn && bq.size() > 0 && bq[0].due <= cyc) begin
                t           = bq.pop_front();
                ib_rvalid_i = 1'b1;
                ib_rdata_i  = memf(t.addr);
                ib_err_i    = errf(t.addr);
            end else begin
                ib_rvalid_i = 1'b0;
                ib_rdata_i  = $urandom;
                ib_err_i    = 1'($urandom_range(1));
            end
            gnt_en = ($urandom_range(99) < gnt_pct);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one redirect cycle; returns in the cycle after it.
    task automatic redirect(input logic [31:0] a);
        br_valid_i = 1'b1;
        br_addr_i  = a;
        step();
        br_valid_i = 1'b0;
        br_addr_i  = $urandom;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc, exp_fa;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        vecs++; if (fault_o !== 1'b0) begin errs++; $display("FAIL rst_fault: got %b want 0", fault_o); end
        vecs++; if (ib_req_o !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", ib_req_o); end
        vecs++; if (pc_o !== 32'h0 || data_o !== 32'h0) begin
            errs++; $display("FAIL rst_outputs: got pc %h data %h want 0 0", pc_o, data_o);
        end
        step();
        rstn   = 1'b1;
        exp_pc = RV;
        exp_fa = RV;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vecs++; if (ib_req_o !== 1'b1 || ib_addr_o !== RV) begin
                    errs++; $display("FAIL rst_first_req: got req %b addr %h want 1 %h", ib_req_o, ib_addr_o, RV);
                end
            end
            if (c < 2) begin
                vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL rst_early_valid: cycle %0d got %b want 0", c, valid_o); end
            end
            if (c == 2) begin
                vecs++; if (valid_o !== 1'b1) begin errs++; $display("FAIL rst_first_valid: got %b want 1", valid_o); end
            end
            if (ib_req_o && ib_gnt_i) begin
                vecs++; if (ib_addr_o !== exp_fa) begin errs++; $display("FAIL rst_fetch_addr: got %h want %h", ib_addr_o, exp_fa); end
                exp_fa += 4;
            end
            if (valid_o && !stall_i) begin
                vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc) || fault_o !== 1'b0) begin
                    errs++; $display("FAIL rst_pop: got pc %h data %h flt %b want pc %h data %h flt 0",
                                     pc_o, data_o, fault_o, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
            end
            step();
        end
        vecs++; if (exp_pc - RV < 32'd16) begin errs++; $display("FAIL rst_progress: got next pc %h want >= %h", exp_pc, RV + 16); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc, exp_fa;
        int grants, pops;
        stall_i = 1'b1;
        redirect(32'h0);
        exp_pc = 32'h0;
        exp_fa = 32'h0;
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ib_req_o && ib_gnt_i) begin
                vecs++; if (ib_addr_o !== exp_fa) begin errs++; $display("FAIL bp_fetch_addr: got %h want %h", ib_addr_o, exp_fa); end
                exp_fa += 4;
                grants++;
            end
            step();
        end
        @(negedge clk);
        vecs++; if (ib_req_o !== 1'b0) begin errs++; $display("FAIL bp_req_held: got %b want 0", ib_req_o); end
        vecs++; if (grants !== 2) begin errs++; $display("FAIL bp_grants: got %0d want 2", grants); end
        vecs++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
            errs++; $display("FAIL bp_head: got valid %b pc %h want 1 00000000", valid_o, pc_o);
        end
        step();
        stall_i = 1'b0;
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ib_req_o && ib_gnt_i) begin
                vecs++; if (ib_addr_o !== exp_fa) begin errs++; $display("FAIL bp_fetch_addr2: got %h want %h", ib_addr_o, exp_fa); end
                exp_fa += 4;
            end
            if (valid_o && !stall_i) begin
                vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc)) begin
                    errs++; $display("FAIL bp_pop: got pc %h data %h want pc %h data %h", pc_o, data_o, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
                pops++;
            end
            step();
        end
        vecs++; if (pops < 3) begin errs++; $display("FAIL bp_drain: got %0d pops want >= 3", pops); end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp_pc, exp_fa;
        int k;
        bit first;
        lat = 3;
        redirect(32'h1000);
        for (k = 0; k < 20; k++) begin
            if (bq.size() == 2) break;
            step();
        end
        vecs++; if (k == 20) begin errs++; $display("FAIL rdi_outstanding: got %0d want 2", bq.size()); end
        redirect(32'h2000);
        exp_pc = 32'h2000;
        exp_fa = 32'h2000;
        first  = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (ib_req_o && ib_gnt_i) begin
                vecs++; if (ib_addr_o !== exp_fa) begin errs++; $display("FAIL rdi_fetch_addr: got %h want %h", ib_addr_o, exp_fa); end
                exp_fa += 4;
            end
            if (valid_o && !stall_i) begin
                vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc)) begin
                    errs++; $display("FAIL rdi_pop%s: got pc %h data %h want pc %h data %h",
                                     first ? "_first" : "", pc_o, data_o, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
                first = 1'b0;
            end
            step();
        end
        vecs++; if (first) begin errs++; $display("FAIL rdi_no_delivery: got none want pc 00002000"); end
        lat = 1;
    endtask

    task automatic test_misaligned();
        logic [31:0] exp_pc, exp_fa;
        int k;
        redirect(32'h1000);
        for (k = 0; k < 20; k++) begin
            if (valid_o && ib_rvalid_i) break;
            step();
        end
        vecs++; if (k == 20) begin errs++; $display("FAIL mis_setup: got no rvalid+pop cycle want one"); end
        br_valid_i = 1'b1;
        br_addr_i  = 32'h3003;
        @(negedge clk);
        vecs++; if (ib_req_o !== 1'b0) begin errs++; $display("FAIL mis_req_in_br: got %b want 0", ib_req_o); end
        step();
        br_valid_i = 1'b0;
        @(negedge clk);
        vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL mis_flush: got valid %b want 0", valid_o); end
        vecs++; if (ib_req_o !== 1'b1 || ib_addr_o !== 32'h3000) begin
            errs++; $display("FAIL mis_target: got req %b addr %h want 1 00003000", ib_req_o, ib_addr_o);
        end
        exp_fa = ib_gnt_i ? 32'h3004 : 32'h3000;
        exp_pc = 32'h3000;
        step();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ib_req_o && ib_gnt_i) begin
                vecs++; if (ib_addr_o !== exp_fa) begin errs++; $display("FAIL mis_fetch_addr: got %h want %h", ib_addr_o, exp_fa); end
                exp_fa += 4;
            end
            if (valid_o && !stall_i) begin
                vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc)) begin
                    errs++; $display("FAIL mis_pop: got pc %h data %h want pc %h data %h", pc_o, data_o, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
            end
            step();
        end
    endtask

    task automatic test_bus_error();
        logic [31:0] exp_pc;
        bit saw_fault;
        int reqs_after;
        err_addr = 32'h8;
        err_en   = 1'b1;
        redirect(32'h0);
        exp_pc     = 32'h0;
        saw_fault  = 1'b0;
        reqs_after = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (saw_fault && ib_req_o) reqs_after++;
            if (valid_o && !stall_i) begin
                vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc) || fault_o !== errf(exp_pc)) begin
                    errs++; $display("FAIL err_pop: got pc %h data %h flt %b want pc %h data %h flt %b",
                                     pc_o, data_o, fault_o, exp_pc, memf(exp_pc), errf(exp_pc));
                end
                if (exp_pc == 32'h8) saw_fault = 1'b1;
                exp_pc += 4;
            end
            step();
        end
        vecs++; if (!saw_fault) begin errs++; $display("FAIL err_seen: got no entry at 00000008 want fault entry"); end
        vecs++; if (reqs_after !== 0) begin errs++; $display("FAIL err_halt: got %0d requests want 0", reqs_after); end
        vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL err_drained: got valid %b want 0", valid_o); end
        redirect(32'h40);
        exp_pc = 32'h40;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid_o && !stall_i) begin
                vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc) || fault_o !== 1'b0) begin
                    errs++; $display("FAIL err_resume: got pc %h data %h flt %b want pc %h data %h flt 0",
                                     pc_o, data_o, fault_o, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
            end
            step();
        end
        vecs++; if (exp_pc == 32'h40) begin errs++; $display("FAIL err_resume_none: got no entry want pc 00000040"); end
        err_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc, exp_fa;
        int pops;
        redirect(32'hFFFF_FFF8);
        exp_pc = 32'hFFFF_FFF8;
        exp_fa = 32'hFFFF_FFF8;
        pops   = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ib_req_o && ib_gnt_i) begin
                vecs++; if (ib_addr_o !== exp_fa) begin errs++; $display("FAIL wrap_fetch_addr: got %h want %h", ib_addr_o, exp_fa); end
                exp_fa += 4;
            end
            if (valid_o && !stall_i) begin
                vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc)) begin
                    errs++; $display("FAIL wrap_pop: got pc %h data %h want pc %h data %h", pc_o, data_o, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
                pops++;
            end
            step();
        end
        vecs++; if (pops < 3) begin errs++; $display("FAIL wrap_count: got %0d pops want >= 3", pops); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_fa;
        int pops;
        gnt_pct = 70;
        redirect(32'h0000_5000);
        exp_pc = 32'h0000_5000;
        exp_fa = 32'h0000_5000;
        pops   = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (br_valid_i) begin
                vecs++; if (ib_req_o !== 1'b0) begin errs++; $display("FAIL rnd_req_in_br: got %b want 0", ib_req_o); end
                exp_pc = br_addr_i & ~32'h3;
                exp_fa = br_addr_i & ~32'h3;
            end else begin
                if (ib_req_o && ib_gnt_i) begin
                    vecs++; if (ib_addr_o !== exp_fa) begin errs++; $display("FAIL rnd_fetch_addr: got %h want %h", ib_addr_o, exp_fa); end
                    exp_fa += 4;
                end
                if (valid_o && !stall_i) begin
                    vecs++; if (pc_o !== exp_pc || data_o !== memf(exp_pc) || fault_o !== 1'b0) begin
                        errs++; $display("FAIL rnd_pop: got pc %h data %h flt %b want pc %h data %h flt 0",
                                         pc_o, data_o, fault_o, exp_pc, memf(exp_pc));
                    end
                    exp_pc += 4;
                    pops++;
                end
            end
            step();
            stall_i    = ($urandom_range(99) < 30);
            lat        = $urandom_range(4, 1);
            br_valid_i = ($urandom_range(99) < 3);
            br_addr_i  = $urandom;
        end
        br_valid_i = 1'b0;
        stall_i    = 1'b0;
        gnt_pct    = 100;
        lat        = 1;
        vecs++; if (pops < 200) begin errs++; $display("FAIL rnd_throughput: got %0d pops want >= 200", pops); end
    endtask

    task automatic test_reset_midop();
        redirect(32'h0000_7000);
        repeat (3) step();
        rstn = 1'b0;
        @(negedge clk);
        vecs++; if (valid_o !== 1'b0 || ib_req_o !== 1'b0 || fault_o !== 1'b0) begin
            errs++; $display("FAIL mid_rst_clear: got valid %b req %b flt %b want 0 0 0", valid_o, ib_req_o, fault_o);
        end
        step();
        step();
        rstn = 1'b1;
        @(negedge clk);
        vecs++; if (ib_req_o !== 1'b1 || ib_addr_o !== RV || valid_o !== 1'b0) begin
            errs++; $display("FAIL mid_rst_restart: got req %b addr %h valid %b want 1 %h 0", ib_req_o, ib_addr_o, valid_o, RV);
        end
        step();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        seed       = $urandom;
        rstn       = 1'b0;
        stall_i    = 1'b0;
        br_valid_i = 1'b0;
        br_addr_i  = '0;
        test_reset();
        test_backpressure();
        test_redirect_inflight();
        test_misaligned();
        test_bus_error();
        test_wrap();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
